// File: rtl/s2p_nibble_deint.sv
// Serial-to-parallel receiver: collects FRAME_BITS serial bits, re-emits them as MSB-first nibbles
// over a valid/ready handshake. Define S2P_DOUBLE_BUF_EN for ping-pong frame banks.
module s2p_nibble_deint #(
    parameter int unsigned FRAME_BITS = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_en,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    input  logic       nib_ready,
    output logic       nib_last,
    output logic       frame_err,
    output logic       ovf_err,
    output logic       busy
);

`ifdef S2P_DOUBLE_BUF_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif

    localparam int unsigned NIBS  = FRAME_BITS / 4;
    localparam int unsigned IDX_W = $clog2(FRAME_BITS);
    localparam int unsigned NIB_W = $clog2(NIBS);
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t                             state, state_n;
    logic [CNT_W-1:0]                   bit_cnt, bit_cnt_n;
    logic [NIB_W-1:0]                   nib_idx, nib_idx_n;
    logic [NBANK-1:0][FRAME_BITS-1:0]   bank_data;
    logic [NBANK-1:0]                   bank_full, full_n;
    logic                               wr_bank, wr_bank_n;
    logic                               rd_bank, rd_bank_n;
    logic [FRAME_BITS-1:0]              rd_word;
    logic [3:0]                         nib_sel;
    logic [IDX_W-1:0]                   bit_idx;
    logic                               xfer, last_xfer, wr_free;
    logic                               accept, drop, frame_done, abort;

    assign nib_valid = (state == DRAIN);
    assign bit_idx   = bit_cnt[IDX_W-1:0];

    always_comb begin
        xfer       = nib_valid && nib_ready;
        last_xfer  = xfer && (nib_idx == LAST_NIB);
        // A bank freed by this cycle's final transfer may take the incoming bit immediately.
        wr_free    = !bank_full[wr_bank] || (last_xfer && (rd_bank == wr_bank));
        accept     = ser_en && wr_free;
        drop       = ser_en && !wr_free;
        frame_done = accept && (bit_cnt == LAST_BIT);
        abort      = !ser_en && (bit_cnt != '0);

        full_n = bank_full;
        if (last_xfer)
            full_n[rd_bank] = 1'b0;
        if (frame_done)
            full_n[wr_bank] = 1'b1;

        rd_bank_n = rd_bank;
        if (last_xfer)
            rd_bank_n = (NBANK == 2) ? ~rd_bank : rd_bank;
        wr_bank_n = wr_bank;
        if (frame_done)
            wr_bank_n = (NBANK == 2) ? ~wr_bank : wr_bank;

        state_n = full_n[rd_bank_n] ? DRAIN : COLLECT;

        nib_idx_n = nib_idx;
        if (last_xfer)
            nib_idx_n = '0;
        else if (xfer)
            nib_idx_n = nib_idx + NIB_W'(1);

        bit_cnt_n = bit_cnt;
        if (frame_done || abort)
            bit_cnt_n = '0;
        else if (accept)
            bit_cnt_n = bit_cnt + CNT_W'(1);
    end

    always_comb begin
        rd_word = bank_data[rd_bank];
        nib_sel = '0;
        for (int unsigned j = 0; j < NIBS; j++) begin
            if (nib_idx == NIB_W'(j))
                nib_sel = rd_word[FRAME_BITS-1-4*j -: 4];
        end
    end

    assign nib_out  = nib_valid ? nib_sel : '0;
    assign nib_last = nib_valid && (nib_idx == LAST_NIB);
    assign busy     = (bit_cnt != '0) || nib_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            bit_cnt   <= '0;
            nib_idx   <= '0;
            bank_data <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            nib_idx   <= nib_idx_n;
            bank_full <= full_n;
            wr_bank   <= wr_bank_n;
            rd_bank   <= rd_bank_n;
            frame_err <= abort;
            ovf_err   <= ovf_err | drop;
            if (accept)
                bank_data[wr_bank][bit_idx] <= ser_in;
        end
    end

endmodule

// File: tb/tb_s2p_nibble_deint.sv
// Self-checking bench for s2p_nibble_deint: vector table plus hand-written corner sequences,
// with a queue scoreboard of expected {last, nibble} per transfer.
module tb_s2p_nibble_deint;

    logic       clk;
    logic       rst;
    logic       ser_in;
    logic       ser_en;
    logic [3:0] nib_out;
    logic       nib_valid;
    logic       nib_ready;
    logic       nib_last;
    logic       frame_err;
    logic       ovf_err;
    logic       busy;

    s2p_nibble_deint #(.FRAME_BITS(64), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_en    (ser_en),
        .nib_out   (nib_out),
        .nib_valid (nib_valid),
        .nib_ready (nib_ready),
        .nib_last  (nib_last),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] frame;
        logic [63:0] exp_seq;
        int unsigned rdy_mode;
    } vec_t;

    vec_t        vecs[4];
    logic [4:0]  sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        hold_prev = 1'b0;
    logic [3:0]  out_prev  = '0;
    logic        last_prev = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // expected nibble j is exp_seq[63-4j -: 4]
    task automatic push_frame(input logic [63:0] exp_seq);
        for (int j = 0; j < 16; j++)
            sb.push_back({(j == 15), exp_seq[63-4*j -: 4]});
    endtask

    // Called just after a rising edge; drives inputs, checks outputs, advances one clock.
    task automatic cycle(input logic si, input logic se, input logic rdy);
        logic [4:0] e;
        ser_in    = si;
        ser_en    = se;
        nib_ready = rdy;
        #1;
        if (hold_prev)
            check("hold_stable", {nib_valid, nib_last, nib_out}, {1'b1, last_prev, out_prev});
        if (nib_valid && rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_nibble", {nib_last, nib_out}, 5'h1f);
            end else begin
                e = sb.pop_front();
                check("nibble", {nib_last, nib_out}, e);
            end
        end else if (!nib_valid) begin
            check("idle_last", nib_last, 0);
        end
        hold_prev = nib_valid && !rdy;
        out_prev  = nib_out;
        last_prev = nib_last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] frame);
        for (int k = 0; k < 64; k++)
            cycle(frame[k], 1'b1, 1'b1);
    endtask

    task automatic drain(input int unsigned mode, output int unsigned ncyc);
        logic r;
        ncyc = 0;
        while (sb.size() != 0 && ncyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (ncyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            cycle(1'b0, 1'b0, r);
            ncyc++;
        end
        check("drain_done", sb.size(), 0);
        check("valid_after_drain", nib_valid, 0);
        check("busy_after_drain", busy, 0);
    endtask

    initial begin
        int unsigned nc;

        vecs[0] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0};
        vecs[1] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1};
        vecs[2] = '{64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 0};
        vecs[3] = '{64'h5A3C0FF096E1D2B4, 64'h5A3C0FF096E1D2B4, 2};

        rst       = 1'b0;
        ser_in    = 1'b0;
        ser_en    = 1'b0;
        nib_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_nib_valid", nib_valid, 0);
        check("rst_nib_out", nib_out, 0);
        check("rst_nib_last", nib_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);

        for (int v = 0; v < 4; v++) begin
            push_frame(vecs[v].exp_seq);
            send_frame(vecs[v].frame);
            drain(vecs[v].rdy_mode, nc);
            if (vecs[v].rdy_mode == 0)
                check("drain_cycles", nc, 16);
            check("vec_ovf_err", ovf_err, 0);
            check("vec_frame_err", frame_err, 0);
        end

        // abort after 20 bits, then a clean frame
        for (int k = 0; k < 20; k++)
            cycle(1'(k & 1), 1'b1, 1'b1);
        check("abort_busy_before", busy, 1);
        cycle(1'b0, 1'b0, 1'b1);
        check("abort_frame_err_pulse", frame_err, 1);
        check("abort_busy_cleared", busy, 0);
        check("abort_no_valid", nib_valid, 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("abort_frame_err_single", frame_err, 0);
        push_frame(64'hFEDCBA9876543210);
        send_frame(64'hFEDCBA9876543210);
        drain(0, nc);
        check("abort_next_ovf", ovf_err, 0);

`ifdef S2P_DOUBLE_BUF_EN
        push_frame(64'h0123456789ABCDEF);
        push_frame(64'hFEDCBA9876543210);
        send_frame(64'h0123456789ABCDEF);
        send_frame(64'hFEDCBA9876543210);
        drain(0, nc);
        check("dbl_ovf_err", ovf_err, 0);
        check("dbl_frame_err", frame_err, 0);
`else
        push_frame(64'h0123456789ABCDEF);
        send_frame(64'h0123456789ABCDEF);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1);
        check("ovf_before", ovf_err, 0);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, 1'b0);
        check("ovf_set", ovf_err, 1);
        check("ovf_held_nibble", nib_out, 4'h3);
        drain(0, nc);
        check("ovf_sticky", ovf_err, 1);
        check("ovf_no_frame_err", frame_err, 0);
`endif

        // reset in the middle of a drain
        push_frame(64'h0123456789ABCDEF);
        send_frame(64'h0123456789ABCDEF);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b1);
        check("rst_mid_remaining", sb.size(), 11);
        rst = 1'b0;
        #1;
        check("rst_mid_valid", nib_valid, 0);
        check("rst_mid_out", nib_out, 0);
        check("rst_mid_last", nib_last, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovf", ovf_err, 0);
        sb.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1);
        check("rst_release_idle", nib_valid, 0);
        push_frame(64'hAAAA5555AAAA5555);
        send_frame(64'hAAAA5555AAAA5555);
        drain(0, nc);
        check("rst_frame_cycles", nc, 16);

        // next frame's first bit coincides with the last-nibble transfer
        push_frame(64'hFEDCBA9876543210);
        send_frame(64'hFEDCBA9876543210);
        for (int i = 0; i < 15; i++)
            cycle(1'b0, 1'b0, 1'b1);
        check("sim_last_pending", nib_last, 1);
        push_frame(64'h0123456789ABCDEF);
        begin
            logic [63:0] fb;
            fb = 64'h0123456789ABCDEF;
            for (int k = 0; k < 64; k++)
                cycle(fb[k], 1'b1, 1'b1);
        end
        check("sim_ovf_err", ovf_err, 0);
        check("sim_frame_err", frame_err, 0);
        drain(0, nc);
        check("sim_drain_cycles", nc, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
